// File: rtl/zerocpu_pkg.sv
// zerocpu_pkg: shared register-file sizes, scoreboard depth and scoreboard FSM states
package zerocpu_pkg;
   localparam int REG_AW  = 5;
   localparam int NREG    = 32;
   localparam int MAXPEND = 4;
   localparam int CNT_W   = $clog2(MAXPEND + 1);
   typedef enum logic {SB_IDLE, SB_DRAIN} sb_state_e;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/writeback/fence signals between the pipeline and the hazard scoreboard
interface hazard_scoreboard_if;
   import zerocpu_pkg::*;
   logic [REG_AW-1:0] rs1ReadAddr;
   logic [REG_AW-1:0] rs2ReadAddr;
   logic              rs1ReadEnable;
   logic              rs2ReadEnable;
   logic              issueValid;
   logic              issueLong;
   logic [REG_AW-1:0] issueRd;
   logic              flush;
   logic              wbValid;
   logic [REG_AW-1:0] wbRd;
   logic              drainReq;
   logic              stallD;
   logic [NREG-1:0]   busyVec;
   logic [CNT_W-1:0]  pendCnt;
   modport master (
      output rs1ReadAddr, rs2ReadAddr, rs1ReadEnable, rs2ReadEnable, issueValid, issueLong,
             issueRd, flush, wbValid, wbRd, drainReq,
      input  stallD, busyVec, pendCnt
   );
   modport slave (
      input  rs1ReadAddr, rs2ReadAddr, rs1ReadEnable, rs2ReadEnable, issueValid, issueLong,
             issueRd, flush, wbValid, wbRd, drainReq,
      output stallD, busyVec, pendCnt
   );
endinterface

// File: rtl/sb_busy_vec.sv
// sb_busy_vec: pending-write bitmap with set/clear ports and a matching population counter
module sb_busy_vec
   import zerocpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              set,
   input  logic [REG_AW-1:0] set_rd,
   input  logic              clr,
   input  logic [REG_AW-1:0] clr_rd,
   output logic [NREG-1:0]   busy_q,
   output logic [CNT_W-1:0]  cnt_q
);
   logic [NREG-1:0]  busy_d;
   logic [CNT_W-1:0] cnt_d;
   // apply set and clear (never the same register), keep x0 clear, count moves by set - clr
   always_comb begin
      busy_d = busy_q;
      if (set) busy_d[set_rd] = 1'b1;
      if (clr) busy_d[clr_rd] = 1'b0;
      busy_d[0] = 1'b0;
      cnt_d = cnt_q + CNT_W'(set) - CNT_W'(clr);
   end
   // bitmap and count registers
   always_ff @(posedge clk) begin
      busy_q <= rst ? '0 : busy_d;
      cnt_q  <= rst ? '0 : cnt_d;
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode stall controller for long-latency writes; SB_WB_BYPASS_EN lets a same-cycle writeback satisfy a source
module hazard_scoreboard
   import zerocpu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   hazard_scoreboard_if.slave sb
);
   logic [NREG-1:0]  busy;
   logic [CNT_W-1:0] cnt;
   sb_state_e        state_q, state_d;
   logic             byp1, byp2, hazard, waw, full, stall, set, clr;
   // hazard/waw/full compares, stall and the set/clear requests for the bitmap
   always_comb begin
`ifdef SB_WB_BYPASS_EN
      byp1 = sb.wbValid && sb.wbRd == sb.rs1ReadAddr;
      byp2 = sb.wbValid && sb.wbRd == sb.rs2ReadAddr;
`else
      byp1 = 1'b0;
      byp2 = 1'b0;
`endif
      hazard = (sb.rs1ReadEnable && sb.rs1ReadAddr != '0 && busy[sb.rs1ReadAddr] && !byp1) ||
               (sb.rs2ReadEnable && sb.rs2ReadAddr != '0 && busy[sb.rs2ReadAddr] && !byp2);
      waw    = sb.issueValid && sb.issueRd != '0 && busy[sb.issueRd];
      full   = sb.issueValid && sb.issueLong && cnt == CNT_W'(MAXPEND);
      stall  = !sb.flush && (hazard || waw || full || state_q == SB_DRAIN || (sb.drainReq && cnt != '0));
      set    = sb.issueValid && sb.issueLong && sb.issueRd != '0 && !stall && !sb.flush;
      clr    = sb.wbValid && sb.wbRd != '0 && busy[sb.wbRd];
   end
   // fence drain FSM: leave on the edge of the last clear, or when the fence is flushed
   always_comb begin
      state_d = (state_q == SB_IDLE)
              ? ((sb.drainReq && cnt != '0 && !sb.flush) ? SB_DRAIN : SB_IDLE)
              : ((sb.flush || cnt == '0 || (cnt == CNT_W'(1) && clr)) ? SB_IDLE : SB_DRAIN);
   end
   // FSM state register
   always_ff @(posedge clk) begin
      state_q <= rst ? SB_IDLE : state_d;
   end
   sb_busy_vec u_busy (
      .clk    (clk),
      .rst    (rst),
      .set    (set),
      .set_rd (sb.issueRd),
      .clr    (clr),
      .clr_rd (sb.wbRd),
      .busy_q (busy),
      .cnt_q  (cnt)
   );
   assign sb.stallD  = stall;
   assign sb.busyVec = busy;
   assign sb.pendCnt = cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: random stimulus against a list-based scoreboard model, queued register checks
module tb_hazard_scoreboard;
   import zerocpu_pkg::*;
   typedef struct packed {
      logic [NREG-1:0]  b;
      logic [CNT_W-1:0] c;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   hazard_scoreboard_if sb_if ();
   hazard_scoreboard dut (.clk(clk), .rst(rst), .sb(sb_if));
   always #5 clk = ~clk;
   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;
   exp_t expq[$];
   int   pend[$];
   bit   drain = 0;
   function automatic bit is_busy(int r);
      if (r == 0) return 1'b0;
      foreach (pend[i]) if (pend[i] == r) return 1'b1;
      return 1'b0;
   endfunction
   // monitor: registered outputs after every edge against the value queued before it
   always @(posedge clk) begin
      #1;
      if (expq.size() != 0) begin
         exp_t e;
         e = expq.pop_front();
         nvec++;
         if (sb_if.busyVec !== e.b || sb_if.pendCnt !== e.c) begin
            nerr++;
            $display("FAIL regs cyc=%0d busyVec=%h pendCnt=%0d expected busyVec=%h pendCnt=%0d",
                     cyc, sb_if.busyVec, sb_if.pendCnt, e.b, e.c);
         end
      end
   end
   initial begin
      bit byp;
      int a1, a2, ird, wrd, cnt, wbp;
      bit e1, e2, iv, il, fl, wv, dr, rs;
      bit hz, waw, full, stall, set, clr, ndrain;
      int npend[$];
      exp_t e;
`ifdef SB_WB_BYPASS_EN
      byp = 1'b1;
`else
      byp = 1'b0;
`endif
      {sb_if.rs1ReadEnable, sb_if.rs2ReadEnable, sb_if.issueValid, sb_if.issueLong} = '0;
      {sb_if.flush, sb_if.wbValid, sb_if.drainReq} = '0;
      sb_if.rs1ReadAddr = '0; sb_if.rs2ReadAddr = '0; sb_if.issueRd = '0; sb_if.wbRd = '0;
      @(negedge clk);
      @(negedge clk);
      expq.push_back('0);
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         cyc = n;
         wbp = (n % 400 < 200) ? 5 : 1;
         if (n == 0) begin
            {e1, e2, iv, il, fl, wv, dr, rs} = '0;
            a1 = 0; a2 = 0; ird = 0; wrd = 0;
         end else begin
            a1 = $urandom_range(0, 7); a2 = $urandom_range(0, 7);
            e1 = $urandom_range(0, 1) == 1; e2 = $urandom_range(0, 1) == 1;
            iv = $urandom_range(0, 3) != 0; il = $urandom_range(0, 1) == 1;
            ird = $urandom_range(0, 9);
            wv = $urandom_range(0, wbp) == 0;
            wrd = (pend.size() != 0 && $urandom_range(0, 3) != 0)
                ? pend[$urandom_range(0, pend.size() - 1)] : $urandom_range(0, 7);
            fl = $urandom_range(0, 15) == 0;
            dr = $urandom_range(0, 5) == 0;
            rs = $urandom_range(0, 99) == 0;
         end
         rst = rs;
         sb_if.rs1ReadAddr = a1[REG_AW-1:0]; sb_if.rs2ReadAddr = a2[REG_AW-1:0];
         sb_if.rs1ReadEnable = e1; sb_if.rs2ReadEnable = e2;
         sb_if.issueValid = iv; sb_if.issueLong = il; sb_if.issueRd = ird[REG_AW-1:0];
         sb_if.wbValid = wv; sb_if.wbRd = wrd[REG_AW-1:0];
         sb_if.flush = fl; sb_if.drainReq = dr;
         #1;
         cnt   = pend.size();
         hz    = (e1 && is_busy(a1) && !(byp && wv && wrd == a1)) ||
                 (e2 && is_busy(a2) && !(byp && wv && wrd == a2));
         waw   = iv && is_busy(ird);
         full  = iv && il && cnt == MAXPEND;
         stall = !fl && (hz || waw || full || drain || (dr && cnt != 0));
         nvec++;
         if (sb_if.stallD !== stall) begin
            nerr++;
            $display("FAIL stallD cyc=%0d got=%b expected=%b", n, sb_if.stallD, stall);
         end
         set = iv && il && ird != 0 && !stall && !fl;
         clr = wv && is_busy(wrd);
         npend = {};
         foreach (pend[i]) if (!(clr && pend[i] == wrd)) npend.push_back(pend[i]);
         if (set) npend.push_back(ird);
         ndrain = drain ? !(fl || cnt == 0 || (cnt == 1 && clr)) : (dr && cnt != 0 && !fl);
         if (rs) begin
            npend = {};
            ndrain = 1'b0;
         end
         e = '0;
         foreach (npend[i]) e.b[npend[i]] = 1'b1;
         e.c = CNT_W'(npend.size());
         expq.push_back(e);
         pend = npend;
         drain = ndrain;
      end
      @(negedge clk);
      rst = 1'b0;
      {sb_if.issueValid, sb_if.wbValid, sb_if.flush, sb_if.drainReq} = '0;
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
